// File: rtl/bcd_conv_scheduler.sv
// bcd_conv_scheduler: round-robin shared sequential binary-to-BCD converter.
// One double-dabble iteration per clock; result tagged with requester ID.
// Optional macro BCD_LEADING_BLANK_EN: blank leading zero digits with 4'hF.
module bcd_conv_scheduler #(
   parameter int N_REQ  = 2,
   parameter int WIDTH  = 24,
   parameter int DIGITS = 8,
   parameter int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*WIDTH-1:0]  value,
   output logic [N_REQ-1:0]        grant,
   output logic                    busy,
   output logic                    done,
   output logic [ID_W-1:0]         done_id,
   output logic [4*DIGITS-1:0]     bcd_out,
   output logic                    bcd_valid
);

   localparam int ACC_W = 4 * DIGITS;
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   function automatic bit f_digits_ok();
      logic [255:0] p10;
      p10 = 256'd1;
      for (int unsigned k = 0; k < DIGITS; k++) p10 = p10 * 256'd10;
      return (WIDTH < 256) && (p10 > (256'd1 << WIDTH));
   endfunction

   if (!f_digits_ok()) begin : g_bad_params
      $error("bcd_conv_scheduler: DIGITS too small for WIDTH (need 10^DIGITS > 2^WIDTH)");
   end

`ifdef BCD_LEADING_BLANK_EN
   // Replace leading zero digits by the blank code; digit 0 is always kept.
   function automatic logic [ACC_W-1:0] f_blank(input logic [ACC_W-1:0] a);
      logic lead;
      f_blank = a;
      lead    = 1'b1;
      for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
         if (lead && (a[4*k +: 4] == 4'h0)) f_blank[4*k +: 4] = 4'hF;
         else                               lead = 1'b0;
      end
   endfunction
`endif

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t             r_state, w_state_next;
   logic [WIDTH-1:0]   r_bin;
   logic [ACC_W-1:0]   r_acc;
   logic [CNT_W-1:0]   r_count;
   logic [ID_W-1:0]    r_cur_id;
   logic [ID_W-1:0]    r_rr_ptr;
   logic [ID_W-1:0]    r_done_id;
   logic [ACC_W-1:0]   r_bcd_out;
   logic               r_bcd_valid;

   logic [N_REQ-1:0]   w_rot;
   logic               w_any;
   logic [ID_W-1:0]    w_sel;
   logic [ID_W-1:0]    w_ptr_next;
   logic [WIDTH-1:0]   w_operand;
   logic [ACC_W-1:0]   w_adj;
   logic [ACC_W-1:0]   w_acc_shift;
   logic [WIDTH-1:0]   w_bin_shift;
   logic [ACC_W-1:0]   w_bcd_final;
   logic               w_last;

   assign w_rot       = N_REQ'({req, req} >> r_rr_ptr);
   assign w_ptr_next  = (w_sel == ID_W'(N_REQ - 1)) ? '0 : w_sel + 1'b1;
   assign w_operand   = value[w_sel*WIDTH +: WIDTH];
   // Top adjusted bit falls off the accumulator; it cannot be set when DIGITS is legal.
   assign w_acc_shift = ACC_W'({w_adj, r_bin[WIDTH-1]});
   assign w_bin_shift = r_bin << 1;
   assign w_last      = (r_count == CNT_W'(WIDTH - 1));

`ifdef BCD_LEADING_BLANK_EN
   assign w_bcd_final = f_blank(w_acc_shift);
`else
   assign w_bcd_final = w_acc_shift;
`endif

   assign done_id   = r_done_id;
   assign bcd_out   = r_bcd_out;
   assign bcd_valid = r_bcd_valid;

   // Round-robin pick: first set request at or after the rotating pointer.
   always_comb begin
      logic [ID_W:0] sum;
      w_any = 1'b0;
      w_sel = '0;
      sum   = '0;
      for (int unsigned off = 0; off < N_REQ; off++) begin
         if (!w_any && w_rot[off]) begin
            w_any = 1'b1;
            sum   = {1'b0, r_rr_ptr} + (ID_W+1)'(off);
            if (sum >= (ID_W+1)'(N_REQ)) sum = sum - (ID_W+1)'(N_REQ);
            w_sel = sum[ID_W-1:0];
         end
      end
   end

   // Double-dabble correction: every digit >= 5 gets +3, all from pre-adjust values.
   always_comb begin
      w_adj = r_acc;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (r_acc[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_acc[4*k +: 4] + 4'd3;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // FSM next state and handshake outputs.
   always_comb begin
      w_state_next = r_state;
      grant        = '0;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               grant        = N_REQ'(1) << w_sel;
               w_state_next = S_SHIFT;
            end
         end
         S_SHIFT: begin
            busy = 1'b1;
            if (w_last) w_state_next = S_DONE;
         end
         S_DONE: begin
            busy         = 1'b1;
            done         = 1'b1;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Datapath: operand capture, iteration, and result registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bin       <= '0;
         r_acc       <= '0;
         r_count     <= '0;
         r_cur_id    <= '0;
         r_rr_ptr    <= '0;
         r_done_id   <= '0;
         r_bcd_out   <= '0;
         r_bcd_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_bin    <= w_operand;
                  r_acc    <= '0;
                  r_count  <= '0;
                  r_cur_id <= w_sel;
                  r_rr_ptr <= w_ptr_next;
               end
            end
            S_SHIFT: begin
               r_acc   <= w_acc_shift;
               r_bin   <= w_bin_shift;
               r_count <= r_count + 1'b1;
               if (w_last) begin
                  r_bcd_out   <= w_bcd_final;
                  r_done_id   <= r_cur_id;
                  r_bcd_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// tb_bcd_conv_scheduler: directed checks of bcd_conv_scheduler (N_REQ=2, WIDTH=24, DIGITS=8).
// Expected results follow BCD_LEADING_BLANK_EN when the macro is defined.
module tb_bcd_conv_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req;
   logic [47:0] value;
   logic [1:0]  grant;
   logic        busy;
   logic        done;
   logic [0:0]  done_id;
   logic [31:0] bcd_out;
   logic        bcd_valid;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

`ifdef BCD_LEADING_BLANK_EN
   localparam logic [31:0] B_123456 = 32'hFF123456;
   localparam logic [31:0] B_0      = 32'hFFFFFFF0;
   localparam logic [31:0] B_42     = 32'hFFFFFF42;
   localparam logic [31:0] B_5      = 32'hFFFFFFF5;
   localparam logic [31:0] B_99     = 32'hFFFFFF99;
   localparam logic [31:0] B_1      = 32'hFFFFFFF1;
   localparam logic [31:0] B_123    = 32'hFFFFF123;
   localparam logic [31:0] B_456    = 32'hFFFFF456;
`else
   localparam logic [31:0] B_123456 = 32'h00123456;
   localparam logic [31:0] B_0      = 32'h00000000;
   localparam logic [31:0] B_42     = 32'h00000042;
   localparam logic [31:0] B_5      = 32'h00000005;
   localparam logic [31:0] B_99     = 32'h00000099;
   localparam logic [31:0] B_1      = 32'h00000001;
   localparam logic [31:0] B_123    = 32'h00000123;
   localparam logic [31:0] B_456    = 32'h00000456;
`endif

   bcd_conv_scheduler #(.N_REQ(2), .WIDTH(24), .DIGITS(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .value     (value),
      .grant     (grant),
      .busy      (busy),
      .done      (done),
      .done_id   (done_id),
      .bcd_out   (bcd_out),
      .bcd_valid (bcd_valid)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   // Cycle counter used to measure grant spacing.
   always @(posedge clk) cyc <= cyc + 1;

   // Hard time limit so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // One conversion: grant in the current cycle, then follow it to done and one cycle beyond.
   task automatic run_conv(input logic [1:0] rq, input logic [23:0] v0, input logic [23:0] v1,
                           input logic [1:0] exp_g, input logic [31:0] exp_bcd, input logic exp_id,
                           input bit hold, input logic [1:0] raise, input logic [1:0] exp_next,
                           output int gcyc);
      int lat;
      int bcnt;
      bit seen;
      req   = rq;
      value = {v1, v0};
      #1;
      gcyc = cyc;
      chk("grant", 32'(grant), 32'(exp_g));
      chk("busy_at_grant", 32'(busy), 32'd0);
      lat  = 0;
      bcnt = 0;
      seen = 1'b0;
      while (!seen && lat < 40) begin
         step();
         lat++;
         if (lat == 1) begin
            if (!hold) req = req & ~exp_g;
            value = ~value;
         end
         if (lat == 5) req = req | raise;
         #1;
         if (busy) begin
            bcnt++;
            chk("grant_while_busy", 32'(grant), 32'd0);
         end
         if (done) seen = 1'b1;
      end
      chk("done_seen", 32'(seen), 32'd1);
      chk("latency", 32'(lat), 32'd25);
      chk("busy_cycles", 32'(bcnt), 32'd25);
      chk("bcd_out", bcd_out, exp_bcd);
      chk("done_id", 32'(done_id), 32'(exp_id));
      chk("bcd_valid", 32'(bcd_valid), 32'd1);
      step();
      #1;
      chk("done_width", 32'(done), 32'd0);
      chk("busy_after", 32'(busy), 32'd0);
      chk("next_grant", 32'(grant), 32'(exp_next));
      chk("bcd_hold", bcd_out, exp_bcd);
   endtask

   // Directed stimulus sequence.
   initial begin
      int g0, g1, dcnt;
      reset = 1'b1;
      req   = '0;
      value = '0;
      step();
      step();
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_done_id", 32'(done_id), 32'd0);
      chk("rst_bcd_out", bcd_out, 32'd0);
      chk("rst_bcd_valid", 32'(bcd_valid), 32'd0);
      reset = 1'b0;
      step();

      run_conv(2'b01, 24'd123456,   24'd0, 2'b01, B_123456,     1'b0, 1'b0, 2'b00, 2'b00, g0);
      run_conv(2'b01, 24'd16777215, 24'd0, 2'b01, 32'h16777215, 1'b0, 1'b0, 2'b00, 2'b00, g0);
      run_conv(2'b01, 24'd0,        24'd0, 2'b01, B_0,          1'b0, 1'b0, 2'b00, 2'b00, g0);
      run_conv(2'b01, 24'd42,       24'd0, 2'b01, B_42,         1'b0, 1'b0, 2'b00, 2'b00, g0);
      run_conv(2'b01, 24'd10000000, 24'd0, 2'b01, 32'h10000000, 1'b0, 1'b0, 2'b00, 2'b00, g0);

      // Requester 1 arrives mid-conversion; must be granted in the first idle cycle.
      run_conv(2'b01, 24'd5, 24'd99, 2'b01, B_5,  1'b0, 1'b0, 2'b10, 2'b10, g0);
      run_conv(2'b10, 24'd5, 24'd99, 2'b10, B_99, 1'b1, 1'b0, 2'b00, 2'b00, g0);

      // Both requests held: strict alternation, 26 cycles apart.
      run_conv(2'b11, 24'd1, 24'd99, 2'b01, B_1,  1'b0, 1'b1, 2'b00, 2'b10, g0);
      run_conv(2'b11, 24'd1, 24'd99, 2'b10, B_99, 1'b1, 1'b1, 2'b00, 2'b01, g1);
      chk("grant_spacing_1", 32'(g1 - g0), 32'd26);
      run_conv(2'b11, 24'd1, 24'd99, 2'b01, B_1,  1'b0, 1'b1, 2'b00, 2'b10, g0);
      chk("grant_spacing_2", 32'(g0 - g1), 32'd26);
      run_conv(2'b11, 24'd1, 24'd99, 2'b10, B_99, 1'b1, 1'b1, 2'b00, 2'b01, g1);
      chk("grant_spacing_3", 32'(g1 - g0), 32'd26);

      // Requests withdrawn before being granted leave the engine idle.
      req = 2'b00;
      #1;
      chk("dropped_grant", 32'(grant), 32'd0);
      step();
      chk("dropped_busy", 32'(busy), 32'd0);

      // Abort a conversion with reset part-way through the shift phase.
      req   = 2'b01;
      value = {24'd0, 24'd777};
      #1;
      chk("abort_grant", 32'(grant), 32'b01);
      for (int i = 0; i < 10; i++) begin
         step();
         req = 2'b00;
      end
      #1;
      chk("abort_busy_mid", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_bcd_out", bcd_out, 32'd0);
      chk("abort_bcd_valid", 32'(bcd_valid), 32'd0);
      chk("abort_done_id", 32'(done_id), 32'd0);
      step();
      step();
      reset = 1'b0;
      dcnt  = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (done) dcnt++;
      end
      chk("abort_no_done", 32'(dcnt), 32'd0);
      chk("abort_valid_low", 32'(bcd_valid), 32'd0);

      // Pointer is back at requester 0 after reset.
      run_conv(2'b11, 24'd123, 24'd456, 2'b01, B_123, 1'b0, 1'b0, 2'b00, 2'b10, g0);
      run_conv(2'b10, 24'd123, 24'd456, 2'b10, B_456, 1'b1, 1'b0, 2'b00, 2'b00, g0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
